// File: rtl/sram_responder.sv
// sram_responder: block-RAM emulation of an async SRAM pin interface.
// Define SRAM_RESP_INIT_EN to fill the array with INIT_PATTERN after reset.
module sram_responder #(
  parameter int          MEM_ADDR_BITS = 10,
  parameter int          READ_LATENCY  = 2,
  parameter logic [15:0] INIT_PATTERN  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_UB_N,
  input  logic        RamClk,
  input  logic        RamAdv,
  output logic [15:0] write_count,
  output logic [15:0] read_count,
  output logic        protocol_error,
  output logic        init_busy
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);
  localparam bit SHORT_RD = (READ_LATENCY == 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ACTIVE,
    READ_WAIT,
    READ_DRIVE
`ifdef SRAM_RESP_INIT_EN
    , INIT
`endif
  } state_t;

  state_t state;

  logic [18:0] s_addr;
  logic [18:0] a_prev;
  logic [15:0] s_dq;
  logic        s_ce_n;
  logic        s_oe_n;
  logic        s_we_n;
  logic        s_lb_n;
  logic        s_ub_n;
  logic        s_ramclk;
  logic        s_ramadv;
  logic        s2_we_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr   <= '0;
      a_prev   <= '0;
      s_dq     <= '0;
      s_ce_n   <= 1'b1;
      s_oe_n   <= 1'b1;
      s_we_n   <= 1'b1;
      s_lb_n   <= 1'b1;
      s_ub_n   <= 1'b1;
      s_ramclk <= 1'b0;
      s_ramadv <= 1'b0;
      s2_we_n  <= 1'b1;
    end else begin
      s_addr   <= SRAM_ADDR;
      a_prev   <= s_addr;
      s_dq     <= SRAM_DQ;
      s_ce_n   <= SRAM_CE_N;
      s_oe_n   <= SRAM_OE_N;
      s_we_n   <= SRAM_WE_N;
      s_lb_n   <= SRAM_LB_N;
      s_ub_n   <= SRAM_UB_N;
      s_ramclk <= RamClk;
      s_ramadv <= RamAdv;
      s2_we_n  <= s_we_n;
    end
  end

  logic [MEM_ADDR_BITS-1:0] idx;
  logic addr_chg;
  logic wr_req;
  logic rd_req;
  logic commit;
  logic in_init;
  logic perr_set;

  assign idx      = s_addr[MEM_ADDR_BITS-1:0];
  assign addr_chg = (s_addr != a_prev);
  assign wr_req   = !s_ce_n && !s_we_n;
  assign rd_req   = !s_ce_n && !s_oe_n && s_we_n;
  assign commit   = (state == WRITE_ACTIVE) &&
                    ((s_we_n && !s2_we_n) || (s_ce_n && !s_we_n));

`ifdef SRAM_RESP_INIT_EN
  assign in_init = (state == INIT);
`else
  assign in_init = 1'b0;
`endif

  assign perr_set = s_ramclk || s_ramadv ||
                    (!s_ce_n && !s_oe_n && !s_we_n) ||
                    (in_init && (!s_we_n || !s_oe_n));

  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic [15:0]              w_data;
  logic                     w_lb_n;
  logic                     w_ub_n;
  logic [2:0]               lat_cnt;

`ifdef SRAM_RESP_INIT_EN
  logic [MEM_ADDR_BITS-1:0] init_idx;
  logic                     init_run;
  assign init_busy = init_run;
`else
  assign init_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef SRAM_RESP_INIT_EN
      state    <= INIT;
      init_idx <= '0;
      init_run <= 1'b0;
`else
      state    <= IDLE;
`endif
      lat_cnt        <= '0;
      write_count    <= '0;
      read_count     <= '0;
      protocol_error <= 1'b0;
      w_idx          <= '0;
      w_data         <= '0;
      w_lb_n         <= 1'b1;
      w_ub_n         <= 1'b1;
    end else begin
      if (perr_set) protocol_error <= 1'b1;
      // capture every low-WE cycle so the commit uses the final one
      if (wr_req && !in_init) begin
        w_idx  <= idx;
        w_data <= s_dq;
        w_lb_n <= s_lb_n;
        w_ub_n <= s_ub_n;
      end
      if (commit) write_count <= write_count + 16'd1;
      case (state)
        IDLE: begin
          if (wr_req) begin
            state <= WRITE_ACTIVE;
          end else if (rd_req) begin
            if (SHORT_RD) begin
              state      <= READ_DRIVE;
              read_count <= read_count + 16'd1;
            end else begin
              state   <= READ_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        WRITE_ACTIVE: begin
          if (commit || s_we_n) state <= IDLE;
        end
        READ_WAIT: begin
          if (wr_req) begin
            state <= WRITE_ACTIVE;
          end else if (!rd_req) begin
            state <= IDLE;
          end else if (addr_chg) begin
            lat_cnt <= LAT_LOAD;
          end else if (lat_cnt <= 3'd1) begin
            state      <= READ_DRIVE;
            read_count <= read_count + 16'd1;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        READ_DRIVE: begin
          if (wr_req) begin
            state <= WRITE_ACTIVE;
          end else if (!rd_req) begin
            state <= IDLE;
          end else if (addr_chg) begin
            if (SHORT_RD) begin
              read_count <= read_count + 16'd1;
            end else begin
              state   <= READ_WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
`ifdef SRAM_RESP_INIT_EN
        INIT: begin
          if (!init_run) begin
            init_run <= 1'b1;
          end else if (init_idx == MEM_ADDR_BITS'(DEPTH - 1)) begin
            init_run <= 1'b0;
            state    <= IDLE;
          end else begin
            init_idx <= init_idx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  logic [15:0]              mem [DEPTH];
  logic [15:0]              rd_data;
  logic                     mem_we_lo;
  logic                     mem_we_hi;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic [15:0]              mem_wd;

  always_comb begin
    mem_we_lo = 1'b0;
    mem_we_hi = 1'b0;
    mem_idx   = w_idx;
    mem_wd    = w_data;
    if (commit) begin
      mem_we_lo = !w_lb_n;
      mem_we_hi = !w_ub_n;
    end
`ifdef SRAM_RESP_INIT_EN
    if (in_init && init_run) begin
      mem_we_lo = 1'b1;
      mem_we_hi = 1'b1;
      mem_idx   = init_idx;
      mem_wd    = INIT_PATTERN;
    end
`endif
  end

  // array has no reset so it maps to block RAM; read is read-before-write
  always_ff @(posedge clk) begin
    if (mem_we_lo) mem[mem_idx][7:0]  <= mem_wd[7:0];
    if (mem_we_hi) mem[mem_idx][15:8] <= mem_wd[15:8];
    rd_data <= mem[idx];
  end

  logic        dq_oe;
  logic [15:0] dq_out;

  assign dq_oe  = (state == READ_DRIVE) && rd_req && !addr_chg;
  assign dq_out = {s_ub_n ? 8'h00 : rd_data[15:8],
                   s_lb_n ? 8'h00 : rd_data[7:0]};
  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of the SRAM responder.
// Bus is pulled up so a released DQ reads as 16'hFFFF.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] SRAM_ADDR = '0;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N = 1'b1;
  logic        SRAM_OE_N = 1'b1;
  logic        SRAM_WE_N = 1'b1;
  logic        SRAM_LB_N = 1'b1;
  logic        SRAM_UB_N = 1'b1;
  logic        RamClk = 1'b0;
  logic        RamAdv = 1'b0;
  logic [15:0] write_count;
  logic [15:0] read_count;
  logic        protocol_error;
  logic        init_busy;

  logic [15:0] tb_dq = '0;
  logic        tb_drv = 1'b0;

  assign SRAM_DQ = tb_drv ? tb_dq : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (SRAM_DQ[g]);
  end

  sram_responder #(
    .MEM_ADDR_BITS(10),
    .READ_LATENCY(2),
    .INIT_PATTERN(16'h5A5A)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_LB_N(SRAM_LB_N),
    .SRAM_UB_N(SRAM_UB_N),
    .RamClk(RamClk),
    .RamAdv(RamAdv),
    .write_count(write_count),
    .read_count(read_count),
    .protocol_error(protocol_error),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int exp_wc = 0;
  int exp_rc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pins_idle();
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_UB_N = 1'b1;
    tb_drv    = 1'b0;
  endtask

  task automatic write_word(input logic [18:0] a, input logic [15:0] d,
                            input logic lb_n, input logic ub_n);
    SRAM_ADDR = a;
    tb_dq     = d;
    tb_drv    = 1'b1;
    SRAM_LB_N = lb_n;
    SRAM_UB_N = ub_n;
    SRAM_CE_N = 1'b0;
    SRAM_WE_N = 1'b0;
    tick(3);
    pins_idle();
    tick(4);
    exp_wc++;
  endtask

  task automatic read_word(input string tag, input logic [18:0] a,
                           input logic lb_n, input logic ub_n,
                           input logic [15:0] exp);
    SRAM_ADDR = a;
    SRAM_LB_N = lb_n;
    SRAM_UB_N = ub_n;
    SRAM_CE_N = 1'b0;
    SRAM_OE_N = 1'b0;
    tick(2);
    chk({tag, "_early"}, SRAM_DQ, 16'hFFFF);
    tick(1);
    chk(tag, SRAM_DQ, exp);
    exp_rc++;
    pins_idle();
    tick(1);
    chk({tag, "_release"}, SRAM_DQ, 16'hFFFF);
    tick(2);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    for (int i = 0; i < 1500; i++) begin
      tick(1);
      if (init_busy) n++;
      else if (n > 0) break;
    end
    chk(tag, n, 1024);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic bad;
    pins_idle();
    tick(3);
    chk("rst_wc", write_count, 16'd0);
    chk("rst_rc", read_count, 16'd0);
    chk("rst_perr", protocol_error, 1'b0);
    chk("rst_busy", init_busy, 1'b0);
    chk("rst_dq", SRAM_DQ, 16'hFFFF);
    rst_n = 1'b1;

`ifdef SRAM_RESP_INIT_EN
    wait_init("init_len");
    tick(2);
    read_word("init_rd155", 19'h155, 1'b0, 1'b0, 16'h5A5A);
    read_word("init_rd3ff", 19'h3FF, 1'b0, 1'b0, 16'h5A5A);
    write_word(19'h3F0, 16'h1357, 1'b0, 1'b0);
    read_word("pre_sweep", 19'h3F0, 1'b0, 1'b0, 16'h1357);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_wc = 0;
    exp_rc = 0;
    tick(100);
    rst_n = 1'b0;
    tick(2);
    chk("busy_in_rst", init_busy, 1'b0);
    rst_n = 1'b1;
    wait_init("resweep_len");
    tick(2);
    read_word("resweep_rd", 19'h3F0, 1'b0, 1'b0, 16'h5A5A);
`else
    tick(2);
`endif

    write_word(19'h00010, 16'hA5C3, 1'b0, 1'b0);
    chk("wc_first", write_count, 16'(exp_wc));
    read_word("rd_10", 19'h00010, 1'b0, 1'b0, 16'hA5C3);
    chk("rc_first", read_count, 16'(exp_rc));

    write_word(19'h00020, 16'hFFFF, 1'b0, 1'b0);
    write_word(19'h00020, 16'h1234, 1'b0, 1'b1);
    read_word("byte_lane", 19'h00020, 1'b0, 1'b0, 16'hFF34);

    write_word(19'h00400, 16'hBEEF, 1'b0, 1'b0);
    read_word("alias", 19'h00000, 1'b0, 1'b0, 16'hBEEF);

    read_word("lb_off", 19'h00010, 1'b1, 1'b0, 16'hA500);
    chk("wc_mid", write_count, 16'(exp_wc));

    write_word(19'h00001, 16'h1111, 1'b0, 1'b0);
    write_word(19'h00002, 16'h2222, 1'b0, 1'b0);
    SRAM_ADDR = 19'h00001;
    SRAM_LB_N = 1'b0;
    SRAM_UB_N = 1'b0;
    SRAM_CE_N = 1'b0;
    SRAM_OE_N = 1'b0;
    tick(1);
    SRAM_ADDR = 19'h00002;
    tick(1);
    chk("achg_z1", SRAM_DQ, 16'hFFFF);
    tick(1);
    chk("achg_z2", SRAM_DQ, 16'hFFFF);
    tick(1);
    chk("achg_data", SRAM_DQ, 16'h2222);
    exp_rc++;
    chk("achg_rc", read_count, 16'(exp_rc));
    pins_idle();
    tick(3);

    chk("perr_clear", protocol_error, 1'b0);
    SRAM_ADDR = 19'h003F0;
    SRAM_LB_N = 1'b0;
    SRAM_UB_N = 1'b0;
    SRAM_CE_N = 1'b0;
    SRAM_OE_N = 1'b0;
    SRAM_WE_N = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (SRAM_DQ !== 16'hFFFF) bad = 1'b1;
    end
    chk("cont_nodrive", bad, 1'b0);
    chk("cont_perr", protocol_error, 1'b1);
    pins_idle();
    tick(5);
    exp_wc++;
    chk("perr_sticky", protocol_error, 1'b1);
    chk("cont_wc", write_count, 16'(exp_wc));

    rst_n = 1'b0;
    tick(1);
    chk("rst2_perr", protocol_error, 1'b0);
    chk("rst2_wc", write_count, 16'd0);
    chk("rst2_rc", read_count, 16'd0);
    rst_n = 1'b1;
`ifdef SRAM_RESP_INIT_EN
    wait_init("init_len3");
    tick(2);
`else
    tick(2);
    read_word("retain", 19'h00010, 1'b0, 1'b0, 16'hA5C3);
`endif

    chk("perr_pre_adv", protocol_error, 1'b0);
    RamAdv = 1'b1;
    tick(1);
    RamAdv = 1'b0;
    tick(3);
    chk("adv_perr", protocol_error, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
